pi_hsk_rx: RTL and testbench

Parametrised receive side of the Raspberry Pi → FPGA parallel link. It synchronises the Pi request line and runs a full 4-phase request/acknowledge handshake. Each transferred word is captured into an internal FIFO and presented downstream on a valid/ready stream. The acknowledge is withheld while the FIFO is full, which gives the Pi back-pressure. A sticky timeout flag reports a Pi that never releases its request.

---
 rtl/pi_hsk_rx_pkg.sv | 14 +
 rtl/pi_hsk_rx_if.sv | 29 ++
 rtl/pi_hsk_rx_sync_fifo.sv | 53 +++++
 rtl/pi_hsk_rx.sv | 119 +++++++++++
 tb/tb_pi_hsk_rx.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pi_hsk_rx_pkg.sv
// Shared link definitions for the Pi -> FPGA parallel receive path.
// Contents:
//   rx_state_e - handshake FSM state encodings (IDLE, ACK)
//   RX_CNT_W   - width of the accepted-word counter
package pi_hsk_rx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } rx_state_e;

    localparam int RX_CNT_W = 16;

endpackage

// File: rtl/pi_hsk_rx_if.sv
// Handshake and stream signal bundle for pi_hsk_rx.
// Signals:
//   pi_hsk_raw - Pi request, asynchronous to the FPGA clock
//   data       - Pi data bus, held stable by the Pi during a request
//   fpga_hsk   - acknowledge back to the Pi
//   m_data     - downstream head word
//   m_valid    - downstream word available
//   m_ready    - downstream accepts the head word
// Modports: slave = the receiver, master = Pi plus downstream sink.
interface pi_hsk_rx_if #(
    parameter int DATA_W = 8
);
    logic              pi_hsk_raw;
    logic [DATA_W-1:0] data;
    logic              fpga_hsk;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport slave (
        input  pi_hsk_raw, data, m_ready,
        output fpga_hsk, m_data, m_valid
    );

    modport master (
        output pi_hsk_raw, data, m_ready,
        input  fpga_hsk, m_data, m_valid
    );
endinterface

// File: rtl/pi_hsk_rx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pointers only)
//   push/wdata  - write request and word; ignored while full
//   pop/rdata   - read request; rdata is the current head word
//   full/empty  - registered-state status
//   level       - occupancy, 0..DEPTH
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Full is taken from registered state, so a same-cycle pop never frees room.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/pi_hsk_rx.sv
// Receive side of the Raspberry Pi -> FPGA parallel link.
// Synchronises the Pi request, runs the 4-phase req/ack handshake, stores each
// word in a FIFO and presents it on a valid/ready stream. The ack is withheld
// while the FIFO is full; a sticky flag reports a request that is never released.
// Ports:
//   clk         - system clock
//   reset_raw   - asynchronous active-low reset
//   link        - handshake / stream bundle (slave side)
//   level       - FIFO occupancy
//   rx_count    - words accepted since reset, wraps
//   err_timeout - sticky: ack held TIMEOUT cycles without request release
//   err_clr     - clears err_timeout (a same-cycle set wins)
module pi_hsk_rx
    import pi_hsk_rx_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   reset_raw,
    pi_hsk_rx_if.slave             link,
    output logic [$clog2(DEPTH):0] level,
    output logic [RX_CNT_W-1:0]    rx_count,
    output logic                   err_timeout,
    input  logic                   err_clr
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    rx_state_e              state_q, state_d;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   tcnt_clr;
    logic                   tcnt_inc;
    logic                   tmo_hit;
    logic [TW-1:0]          tcnt_q;
    logic [RX_CNT_W-1:0]    rx_cnt_q;

    // Request synchroniser; data is deliberately not registered since the Pi
    // holds it stable for the whole request phase.
    always_ff @(posedge clk or negedge reset_raw) begin
        if (!reset_raw) sync_q <= '0;
        else            sync_q <= {sync_q[SYNC_STAGES-2:0], link.pi_hsk_raw};
    end
    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_raw) begin
        if (!reset_raw) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        tcnt_clr = 1'b0;
        tcnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A full FIFO simply leaves the Pi waiting with no ack.
                if (req_s && !fifo_full) begin
                    push     = 1'b1;
                    tcnt_clr = 1'b1;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_s) state_d  = ST_IDLE;
                else        tcnt_inc = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The ack is the state flop itself, so it is glitch-free toward the Pi.
    assign link.fpga_hsk = (state_q == ST_ACK);

    // Counter saturates at TIMEOUT; the flag sets only on the step that
    // reaches it, so a clear while the request is still held stays cleared.
    assign tmo_hit = tcnt_inc && (tcnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_raw) begin
        if (!reset_raw)                                 tcnt_q <= '0;
        else if (tcnt_clr)                              tcnt_q <= '0;
        else if (tcnt_inc && tcnt_q != TW'(TIMEOUT))    tcnt_q <= tcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_raw) begin
        if (!reset_raw)   err_timeout <= 1'b0;
        else if (tmo_hit) err_timeout <= 1'b1;
        else if (err_clr) err_timeout <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset_raw) begin
        if (!reset_raw) rx_cnt_q <= '0;
        else if (push)  rx_cnt_q <= rx_cnt_q + 1'b1;
    end
    assign rx_count = rx_cnt_q;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_raw),
        .push  (push),
        .wdata (link.data),
        .pop   (link.m_valid && link.m_ready),
        .rdata (link.m_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign link.m_valid = !fifo_empty;
endmodule

// File: tb/tb_pi_hsk_rx.sv
// Self-checking bench for pi_hsk_rx (DATA_W=8, DEPTH=8, SYNC_STAGES=2, TIMEOUT=16).
module tb_pi_hsk_rx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] level;
    logic [15:0] rx_count;
    logic       err_timeout;
    logic       err_clr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];

    pi_hsk_rx_if #(.DATA_W(8)) ifc ();

    pi_hsk_rx #(
        .DATA_W      (8),
        .DEPTH       (8),
        .SYNC_STAGES (2),
        .TIMEOUT     (16)
    ) dut (
        .clk         (clk),
        .reset_raw   (rst_n),
        .link        (ifc),
        .level       (level),
        .rx_count    (rx_count),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every word accepted downstream must match the oldest driven word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ifc.m_valid === 1'b1 && ifc.m_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected none", ifc.m_data);
            end else begin
                chk("pop_data", ifc.m_data, sb.pop_front());
            end
        end
    end

    // Counts posedges until fpga_hsk reads val (sampled on the falling edge).
    task automatic wait_hsk(input logic val, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (ifc.fpga_hsk !== val && edges < 64);
    endtask

    task automatic send_word(input logic [7:0] d, output int rise, output int fall);
        @(posedge clk); #1;
        ifc.data       = d;
        ifc.pi_hsk_raw = 1'b1;
        sb.push_back(d);
        wait_hsk(1'b1, rise);
        chk("ack_rise", ifc.fpga_hsk, 1'b1);
        @(posedge clk); #1;
        ifc.pi_hsk_raw = 1'b0;
        wait_hsk(1'b0, fall);
        chk("ack_fall", ifc.fpga_hsk, 1'b0);
    endtask

    task automatic drain();
        int n;
        @(posedge clk); #1;
        ifc.m_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifc.m_valid === 1'b1 && n < 40);
        @(posedge clk); #1;
        ifc.m_ready = 1'b0;
        chk("drain_valid", ifc.m_valid, 1'b0);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n          = 1'b0;
        ifc.pi_hsk_raw = 1'b0;
        ifc.m_ready    = 1'b0;
        err_clr        = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       rdy;
        int         lvl;
        int         cnt;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rise, fall;

        tbl[0] = '{8'h11, 1'b0, 1, 1};
        tbl[1] = '{8'h22, 1'b0, 2, 2};
        tbl[2] = '{8'h33, 1'b0, 3, 3};
        tbl[3] = '{8'h44, 1'b1, 0, 4};
        tbl[4] = '{8'h55, 1'b0, 1, 5};
        tbl[5] = '{8'h66, 1'b0, 2, 6};
        tbl[6] = '{8'h77, 1'b1, 0, 7};

        // Reset held with the request already high.
        rst_n          = 1'b0;
        ifc.pi_hsk_raw = 1'b1;
        ifc.data       = 8'h3C;
        ifc.m_ready    = 1'b0;
        err_clr        = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_fpga_hsk", ifc.fpga_hsk, 1'b0);
        chk("rst_m_valid", ifc.m_valid, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_err", err_timeout, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.push_back(8'h3C);
        wait_hsk(1'b1, rise);
        chk("rst_release_edges", rise, 3);
        chk("rst_release_ack", ifc.fpga_hsk, 1'b1);
        chk("rst_release_level", level, 1);

        // Reset while in ACK holding a word: FIFO empties, held request is a new word.
        @(posedge clk); #1;
        rst_n = 1'b0;
        ifc.data = 8'h5A;
        #1;
        chk("midrst_fpga_hsk", ifc.fpga_hsk, 1'b0);
        chk("midrst_level", level, 0);
        chk("midrst_m_valid", ifc.m_valid, 1'b0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sb.push_back(8'h5A);
        wait_hsk(1'b1, rise);
        chk("midrst_edges", rise, 3);
        chk("midrst_rx_count", rx_count, 1);
        @(posedge clk); #1 ifc.pi_hsk_raw = 1'b0;
        wait_hsk(1'b0, fall);
        drain();

        // Single transfer.
        do_reset();
        send_word(8'hA5, rise, fall);
        chk("single_rise_edges", rise, 3);
        chk("single_fall_edges", fall, 3);
        chk("single_m_data", ifc.m_data, 8'hA5);
        chk("single_m_valid", ifc.m_valid, 1'b1);
        chk("single_level", level, 1);
        chk("single_rx_count", rx_count, 1);
        drain();

        // Table-driven transfers with varying downstream readiness.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1 ifc.m_ready = tbl[i].rdy;
            send_word(tbl[i].d, rise, fall);
            @(posedge clk); #1 ifc.m_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("tbl%0d_rx_count", i), rx_count, tbl[i].cnt);
            chk($sformatf("tbl%0d_m_valid", i), ifc.m_valid, tbl[i].lvl != 0);
        end

        // Simultaneous push and pop at level 3.
        send_word(8'hC1, rise, fall);
        send_word(8'hC2, rise, fall);
        send_word(8'hC3, rise, fall);
        @(posedge clk); #1;
        ifc.data       = 8'hC4;
        ifc.pi_hsk_raw = 1'b1;
        sb.push_back(8'hC4);
        @(posedge clk);
        @(posedge clk); #1 ifc.m_ready = 1'b1;
        @(negedge clk);
        chk("pushpop_level_before", level, 3);
        @(posedge clk); #1 ifc.m_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_ack", ifc.fpga_hsk, 1'b1);
        chk("pushpop_level", level, 3);
        @(posedge clk); #1 ifc.pi_hsk_raw = 1'b0;
        wait_hsk(1'b0, fall);
        drain();

        // Back-pressure: eight words fill the FIFO, the ninth waits.
        do_reset();
        for (int i = 1; i <= 8; i++) send_word(8'(i), rise, fall);
        chk("bp_level_full", level, 8);
        @(posedge clk); #1;
        ifc.data       = 8'h09;
        ifc.pi_hsk_raw = 1'b1;
        sb.push_back(8'h09);
        repeat (20) @(negedge clk);
        chk("bp_no_ack", ifc.fpga_hsk, 1'b0);
        chk("bp_level_hold", level, 8);
        chk("bp_head", ifc.m_data, 8'h01);
        @(posedge clk); #1 ifc.m_ready = 1'b1;
        @(posedge clk); #1 ifc.m_ready = 1'b0;
        wait_hsk(1'b1, rise);
        chk("bp_ack_after_pop", ifc.fpga_hsk, 1'b1);
        chk("bp_level_refill", level, 8);
        @(posedge clk); #1 ifc.pi_hsk_raw = 1'b0;
        wait_hsk(1'b0, fall);
        chk("bp_rx_count", rx_count, 9);
        drain();

        // Timeout with a clear colliding with the set.
        do_reset();
        @(posedge clk); #1;
        ifc.data       = 8'hEE;
        ifc.pi_hsk_raw = 1'b1;
        sb.push_back(8'hEE);
        wait_hsk(1'b1, rise);
        chk("tmo_ack", ifc.fpga_hsk, 1'b1);
        repeat (15) @(posedge clk);
        #1 err_clr = 1'b1;
        @(negedge clk);
        chk("tmo_not_early", err_timeout, 1'b0);
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("tmo_set_wins", err_timeout, 1'b1);
        chk("tmo_still_ack", ifc.fpga_hsk, 1'b1);
        repeat (5) @(negedge clk);
        chk("tmo_sticky", err_timeout, 1'b1);
        @(posedge clk); #1 ifc.pi_hsk_raw = 1'b0;
        wait_hsk(1'b0, fall);
        chk("tmo_release", ifc.fpga_hsk, 1'b0);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("tmo_cleared", err_timeout, 1'b0);
        drain();

        // Counter wrap.
        do_reset();
        force dut.rx_cnt_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.rx_cnt_q;
        @(negedge clk);
        chk("wrap_preload", rx_count, 16'hFFFE);
        send_word(8'h81, rise, fall);
        chk("wrap_ffff", rx_count, 16'hFFFF);
        send_word(8'h82, rise, fall);
        chk("wrap_zero", rx_count, 16'h0000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
